// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: decodes ALUOp/funct, sequences one op per handshake through the ALU, post-processes nor/slt/jr
module alu_issue_ctrl #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [1:0]   alu_op,
  input  logic [5:0]   funct,
  input  logic [4:0]   shamt,
  input  logic [W-1:0] a_in,
  input  logic [W-1:0] b_in,
  output logic [W-1:0] alu_a,
  output logic [W-1:0] alu_b,
  output logic [3:0]   alu_opcode,
  output logic [4:0]   alu_shamt,
  input  logic [W-1:0] alu_result,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] result,
  output logic         zero,
  output logic         jr_taken,
  output logic [W-1:0] jr_target,
  output logic         illegal
);
  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;
  typedef enum logic [2:0] {C_PLAIN, C_NOR, C_SLT, C_JR, C_ILL} cls_t;
  state_t state_q, state_d;
  cls_t cls_q, cls_d, dec_cls;
  logic [3:0] dec_op, opcode_q, opcode_d;
  logic [4:0] shamt_q, shamt_d;
  logic [W-1:0] a_q, a_d, b_q, b_d, result_q, result_d, jr_target_q, jr_target_d, exec_res;
  logic zero_q, zero_d, jr_taken_q, jr_taken_d, illegal_q, illegal_d, out_valid_q, out_valid_d;
  logic accept, slt_bit;
  assign in_ready = (state_q == IDLE) || (state_q == DONE && out_ready);
  assign accept = in_valid && in_ready;
  always_comb begin
    dec_op = 4'b0000;
    dec_cls = C_ILL;
    case (alu_op)
      2'b00: begin dec_op = 4'b0010; dec_cls = C_PLAIN; end
      2'b01: begin dec_op = 4'b0110; dec_cls = C_PLAIN; end
      2'b10:
        case (funct)
          6'b100000: begin dec_op = 4'b0010; dec_cls = C_PLAIN; end
          6'b100010: begin dec_op = 4'b0110; dec_cls = C_PLAIN; end
          6'b100100: begin dec_op = 4'b0000; dec_cls = C_PLAIN; end
          6'b100101: begin dec_op = 4'b0001; dec_cls = C_PLAIN; end
          6'b100111: begin dec_op = 4'b0001; dec_cls = C_NOR; end
          6'b101010: begin dec_op = 4'b0110; dec_cls = C_SLT; end
          6'b000000: begin dec_op = 4'b0100; dec_cls = C_PLAIN; end
          6'b000010: begin dec_op = 4'b0101; dec_cls = C_PLAIN; end
          6'b001000: begin dec_op = 4'b0011; dec_cls = C_JR; end
          default: ;
        endcase
      default: ;
    endcase
  end
  // slt: differing signs decide directly, so subtraction overflow cannot flip the answer
  assign slt_bit = (a_q[W-1] ^ b_q[W-1]) ? a_q[W-1] : alu_result[W-1];
  assign exec_res = (cls_q == C_PLAIN) ? alu_result :
                    (cls_q == C_NOR)   ? ~alu_result :
                    (cls_q == C_SLT)   ? {{(W-1){1'b0}}, slt_bit} : '0;
  always_comb begin
    state_d = state_q;
    cls_d = cls_q;
    opcode_d = opcode_q;
    shamt_d = shamt_q;
    a_d = a_q;
    b_d = b_q;
    result_d = result_q;
    zero_d = zero_q;
    jr_taken_d = jr_taken_q;
    jr_target_d = jr_target_q;
    illegal_d = illegal_q;
    out_valid_d = out_valid_q;
    if (accept) begin
      a_d = a_in;
      b_d = b_in;
      shamt_d = shamt;
      opcode_d = dec_op;
      cls_d = dec_cls;
    end
    if (state_q == IDLE && in_valid) state_d = EXEC;
    if (state_q == EXEC) begin
      state_d = DONE;
      out_valid_d = 1'b1;
      result_d = exec_res;
      zero_d = exec_res == '0;
      jr_taken_d = cls_q == C_JR;
      illegal_d = cls_q == C_ILL;
      jr_target_d = (cls_q == C_JR) ? a_q : jr_target_q;
    end
    if (state_q == DONE && out_ready) begin
      out_valid_d = 1'b0;
      state_d = in_valid ? EXEC : IDLE;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cls_q <= C_PLAIN;
      opcode_q <= 4'b0000;
      shamt_q <= '0;
      a_q <= '0;
      b_q <= '0;
      result_q <= '0;
      zero_q <= 1'b0;
      jr_taken_q <= 1'b0;
      jr_target_q <= '0;
      illegal_q <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cls_q <= cls_d;
      opcode_q <= opcode_d;
      shamt_q <= shamt_d;
      a_q <= a_d;
      b_q <= b_d;
      result_q <= result_d;
      zero_q <= zero_d;
      jr_taken_q <= jr_taken_d;
      jr_target_q <= jr_target_d;
      illegal_q <= illegal_d;
      out_valid_q <= out_valid_d;
    end
  end
  assign alu_a = a_q;
  assign alu_b = b_q;
  assign alu_opcode = opcode_q;
  assign alu_shamt = shamt_q;
  assign result = result_q;
  assign zero = zero_q;
  assign jr_taken = jr_taken_q;
  assign jr_target = jr_target_q;
  assign illegal = illegal_q;
  assign out_valid = out_valid_q;
endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb_alu_issue_ctrl: random and directed ops against a semantic reference model, with an ALU model closing the loop
module tb_alu_issue_ctrl;
  logic clk = 0, rst_n = 0, in_valid = 0, out_ready = 0;
  logic [1:0] alu_op = 0;
  logic [5:0] funct = 0;
  logic [4:0] shamt = 0;
  logic [31:0] a_in = 0, b_in = 0, alu_result;
  logic in_ready, out_valid, zero, jr_taken, illegal;
  logic [31:0] alu_a, alu_b, result, jr_target;
  logic [3:0] alu_opcode;
  logic [4:0] alu_shamt;
  int n_vec = 0, n_err = 0;
  logic [31:0] exp_jt = 0;
  logic [5:0] fns [9] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h2a, 6'h00, 6'h02, 6'h08};

  alu_issue_ctrl #(.W(32)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .alu_op(alu_op), .funct(funct), .shamt(shamt), .a_in(a_in), .b_in(b_in),
    .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode), .alu_shamt(alu_shamt),
    .alu_result(alu_result), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .zero(zero), .jr_taken(jr_taken), .jr_target(jr_target),
    .illegal(illegal)
  );

  always #5 clk = ~clk;

  always_comb begin
    alu_result = 32'h0;
    case (alu_opcode)
      4'b0000: alu_result = alu_a & alu_b;
      4'b0001: alu_result = alu_a | alu_b;
      4'b0010: alu_result = alu_a + alu_b;
      4'b0110: alu_result = alu_a - alu_b;
      4'b0100: alu_result = alu_a << alu_shamt;
      4'b0101: alu_result = alu_a >> alu_shamt;
      4'b0011: alu_result = alu_a;
      default: alu_result = 32'h0;
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit legal(input logic [1:0] op, input logic [5:0] fn);
    if (op < 2) return 1;
    if (op == 3) return 0;
    foreach (fns[i]) if (fns[i] == fn) return 1;
    return 0;
  endfunction

  function automatic logic [3:0] ref_opc(input logic [1:0] op, input logic [5:0] fn);
    if (!legal(op, fn)) return 4'b0000;
    if (op == 0) return 4'b0010;
    if (op == 1) return 4'b0110;
    case (fn)
      6'h20: return 4'b0010;
      6'h22, 6'h2a: return 4'b0110;
      6'h24: return 4'b0000;
      6'h25, 6'h27: return 4'b0001;
      6'h00: return 4'b0100;
      6'h02: return 4'b0101;
      default: return 4'b0011;
    endcase
  endfunction

  function automatic logic [31:0] ref_res(input logic [1:0] op, input logic [5:0] fn, input logic [4:0] sh,
                                          input logic [31:0] a, input logic [31:0] b);
    if (!legal(op, fn)) return 0;
    if (op == 0) return a + b;
    if (op == 1) return a - b;
    case (fn)
      6'h20: return a + b;
      6'h22: return a - b;
      6'h24: return a & b;
      6'h25: return a | b;
      6'h27: return ~(a | b);
      6'h2a: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      6'h00: return a << sh;
      6'h02: return a >> sh;
      default: return 0;
    endcase
  endfunction

  task automatic run_op(input logic [1:0] op, input logic [5:0] fn, input logic [4:0] sh,
                        input logic [31:0] a, input logic [31:0] b, input int stall);
    logic [31:0] r;
    bit jr, il;
    r = ref_res(op, fn, sh, a, b);
    jr = (op == 2) && (fn == 6'h08);
    il = !legal(op, fn);
    alu_op = op; funct = fn; shamt = sh; a_in = a; b_in = b;
    in_valid = 1; out_ready = 1;
    #1 chk("in_ready_accept", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 0; alu_op = 2'($urandom); funct = 6'($urandom); shamt = 5'($urandom);
    a_in = $urandom; b_in = $urandom;
    chk("exec_opcode", alu_opcode, ref_opc(op, fn));
    chk("exec_a", alu_a, a);
    chk("exec_b", alu_b, b);
    chk("exec_shamt", alu_shamt, sh);
    chk("exec_out_valid", out_valid, 0);
    chk("exec_in_ready", in_ready, 0);
    if (jr) exp_jt = a;
    @(posedge clk); #1;
    chk("done_out_valid", out_valid, 1);
    chk("result", result, r);
    chk("zero", zero, r == 0);
    chk("jr_taken", jr_taken, jr);
    chk("illegal", illegal, il);
    chk("jr_target", jr_target, exp_jt);
    for (int k = 0; k < stall; k++) begin
      out_ready = 0; in_valid = 1'($urandom); a_in = $urandom;
      @(posedge clk); #1;
      chk("stall_in_ready", in_ready, 0);
      chk("stall_out_valid", out_valid, 1);
      chk("stall_result", result, r);
      chk("stall_zero", zero, r == 0);
      chk("stall_alu_a", alu_a, a);
    end
    in_valid = 0; out_ready = 1;
  endtask

  task automatic go_idle();
    @(posedge clk); #1;
    chk("idle_out_valid", out_valid, 0);
    chk("idle_in_ready", in_ready, 1);
  endtask

  initial begin
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_opcode", alu_opcode, 0);
    chk("rst_result", result, 0);
    chk("rst_alu_a", alu_a, 0);
    rst_n = 1;
    @(negedge clk);
    run_op(2'b10, 6'h20, 0, 7, 5, 0);
    run_op(2'b10, 6'h27, 0, 32'hF0F0_0000, 32'h0000_00FF, 0);
    run_op(2'b10, 6'h2a, 0, 32'hFFFF_FFFF, 1, 0);
    run_op(2'b10, 6'h2a, 0, 32'h7FFF_FFFF, 32'h8000_0000, 0);
    run_op(2'b10, 6'h2a, 0, 3, 3, 0);
    run_op(2'b01, 6'h3f, 0, 32'h1234, 32'h1234, 0);
    run_op(2'b10, 6'h00, 4, 1, 0, 0);
    run_op(2'b10, 6'h02, 31, 32'h8000_0000, 0, 0);
    run_op(2'b10, 6'h08, 0, 32'h0040_0020, 9, 0);
    run_op(2'b11, 6'h20, 0, 5, 6, 3);
    run_op(2'b00, 6'h00, 0, 32'hFFFF_FFFF, 1, 0);
    go_idle();
    alu_op = 2'b10; funct = 6'h20; a_in = 1; b_in = 2; in_valid = 1;
    @(posedge clk); #1;
    in_valid = 0; rst_n = 0;
    #1;
    chk("rstx_out_valid", out_valid, 0);
    chk("rstx_in_ready", in_ready, 1);
    chk("rstx_result", result, 0);
    chk("rstx_jr_target", jr_target, 0);
    exp_jt = 0;
    @(negedge clk); rst_n = 1;
    repeat (3) begin
      @(posedge clk); #1;
      chk("rstx_no_result", out_valid, 0);
    end
    for (int i = 0; i < 80; i++) begin
      logic [1:0] op;
      logic [5:0] fn;
      logic [31:0] a, b;
      op = 2'($urandom_range(0, 3));
      fn = ($urandom_range(0, 3) == 0) ? 6'($urandom) : fns[$urandom_range(0, 8)];
      a = $urandom;
      b = ($urandom_range(0, 4) == 0) ? a : $urandom;
      if ($urandom_range(0, 3) == 0) a[31] = ~b[31];
      run_op(op, fn, 5'($urandom), a, b, $urandom_range(0, 3));
      if ($urandom_range(0, 2) == 0) go_idle();
    end
    go_idle();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
Drives the ALU's OpCode/Shift_amt/A/B interface from the decode stage. It decodes MIPS ALUOp+funct into the 4-bit ALU opcode and registers the operands. It sequences each operation through a valid/ready handshake and post-processes the ALU result. The ALU itself has no nor or slt, so this block emulates nor as OR-then-invert and slt as SUB plus a sign fix. It sits between the ID/EX register and the ALU.

Parameters:
W, 32, operand/result width (ALU port width; only 32 is supported)

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  decode stage presents an operation
in_ready  out  1  block can accept an operation this cycle
alu_op  in  2  main-control ALUOp: 00 add, 01 sub, 10 R-type (use funct), 11 illegal
funct  in  6  instruction[5:0]
shamt  in  5  instruction[10:6]
a_in  in  W  operand A (rs)
b_in  in  W  operand B (rt or sign-extended imm)
alu_a  out  W  to ALU A
alu_b  out  W  to ALU B
alu_opcode  out  4  to ALU OpCode
alu_shamt  out  5  to ALU Shift_amt
alu_result  in  W  from ALU Result (combinational from alu_* outputs)
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result
result  out  W  final result
zero  out  1  result == 0
jr_taken  out  1  operation was jr; jr_target valid
jr_target  out  W  jump register target (= A)
illegal  out  1  unsupported alu_op/funct

Behaviour:
- Reset (async, rst_n=0): state IDLE; in_ready=1 after reset; out_valid=0; alu_a, alu_b, result, jr_target = 0; alu_opcode=4'b0000; alu_shamt=0; zero=0; jr_taken=0; illegal=0. Reset mid-operation discards the operation; no result is produced.
- FSM states and transitions:
  - IDLE: in_ready=1. On in_valid, go to EXEC.
  - EXEC: in_ready=0. Always go to DONE.
  - DONE: out_valid=1. On out_ready with in_valid, go to EXEC. On out_ready without in_valid, go to IDLE. Otherwise hold.
- Handshake:
  - in_ready = (state==IDLE) || (state==DONE && out_ready).
  - Accept = in_valid && in_ready. On accept, latch a_in to alu_a, b_in to alu_b, shamt to alu_shamt, the decoded opcode to alu_opcode, and the internal op class.
- Decode:
  - alu_op 00 -> 0010 (add). alu_op 01 -> 0110 (sub).
  - alu_op 10, by funct:
    - 100000 -> 0010 (add)
    - 100010 -> 0110 (sub)
    - 100100 -> 0000 (and)
    - 100101 -> 0001 (or)
    - 100111 -> 0001 (or), class NOR
    - 101010 -> 0110 (sub), class SLT
    - 000000 -> 0100 (sll)
    - 000010 -> 0101 (srl)
    - 001000 -> 0011 (jr), class JR
  - Any other funct, or alu_op 11 -> opcode 0000, class ILLEGAL.
- EXEC captures into result on the EXEC->DONE edge:
  - PLAIN: result = alu_result.
  - NOR: result = ~alu_result.
  - SLT: result = {31'b0, (a[31]^b[31]) ? a[31] : alu_result[31]}. This is correct under subtraction overflow.
  - JR: result = 0; jr_target = alu_a; jr_taken = 1.
  - ILLEGAL: result = 0; illegal = 1.
  - zero = (final result == 0). It is computed here, not taken from the ALU's zero flag.
- Latency and hold:
  - Accept in cycle N gives out_valid in cycle N+2.
  - With out_ready held high, throughput is one op per 2 cycles.
  - All outputs hold stable while out_valid && !out_ready.
  - alu_* outputs hold their last values in IDLE.
- Arithmetic: add/sub wrap modulo 2^32, with no overflow flag. Shifts are logical and use shamt only; shamt=0 passes A through.

Test Plan:
- add: alu_op=10, funct=100000, A=7, B=5, out_ready=1 -> alu_opcode=0010 in EXEC; out_valid at N+2; result=12, zero=0.
- nor: funct=100111, A=0xF0F0_0000, B=0x0000_00FF -> alu_opcode=0001; result=0x0F0F_FF00.
- slt signed and overflow cases, funct=101010:
  - A=-1, B=1 -> result=1.
  - A=0x7FFF_FFFF, B=0x8000_0000 -> result=0, despite the SUB sign bit being 1.
  - A=B=3 -> result=0, zero=1.
- beq-style sub: alu_op=01, A=B=0x1234 -> result=0, zero=1. Shifts: sll funct=000000, shamt=4, A=0x1 -> 0x10; srl shamt=31, A=0x8000_0000 -> 0x1.
- jr and illegal:
  - funct=001000, A=0x0040_0020 -> jr_taken=1, jr_target=0x0040_0020, result=0.
  - alu_op=11 -> illegal=1, result=0.
- Backpressure and reset:
  - out_ready=0 for 3 cycles in DONE -> outputs stable, in_ready=0.
  - Then out_ready=1 with in_valid=1 -> back-to-back accept (DONE->EXEC).
  - rst_n pulsed low during EXEC -> out_valid=0 immediately and no result emitted.
